// File: rtl/vga_pkg.sv
// vga_pkg -- shared constants for the VGA sync generator.
// Holds the default 640x480@60 timing (pixels / lines), the derived
// totals, the coordinate and colour widths, and a helper that sizes
// the pixel-clock divider.
package vga_pkg;

  localparam int COORD_W = 11;
  localparam int COLOR_W = 3;
  localparam int FCNT_W  = 16;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // A divide-by-1 still needs a 1-bit register so the port width is legal.
  function automatic int div_width(int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_if.sv
// vga_sync_if -- bundle between the sync generator, the pixel renderer
// and the DAC side.
//   x, y          : current pixel coordinate (generator -> renderer)
//   r, g, b       : renderer colour for x, y, combinational (renderer -> generator)
//   vga_r/g/b     : registered colour to the DAC
//   hsync, vsync  : active-low sync pulses
//   active        : displayed pixel is inside the visible area
//   frame_start   : one-clk pulse when x=0, y=0 is presented
//   frame_count   : completed-frame counter (zero when the counter is not built)
// There is no handshake: the renderer is a pure function of x, y and the
// generator samples r, g, b on every pixel tick.
interface vga_sync_if;
  import vga_pkg::*;

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               hsync;
  logic               vsync;
  logic               active;
  logic               frame_start;
  logic [FCNT_W-1:0]  frame_count;

  modport master (
    output x, y, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start, frame_count,
    input  r, g, b
  );

  modport slave (
    input  x, y, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start, frame_count,
    output r, g, b
  );
endinterface

// File: rtl/vga_counter.sv
// vga_counter -- modulo-MODULUS up counter with enable.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   en       : advance by one on this clk
//   count    : current value, 0..MODULUS-1
//   wrap     : combinational, high on the enabled clk that returns count to 0
module vga_counter #(
  parameter int MODULUS = 800,
  parameter int W       = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync.sv
// vga_sync -- VGA timing generator with a registered output stage.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : vga_sync_if.master (coordinates out, renderer colour in,
//          DAC colour / syncs / active / frame_start / frame_count out)
// A pixel tick fires every CLK_DIV clks. x, y advance on each tick; the
// output stage samples the current x, y and the renderer colour on the
// same tick, so everything toward the DAC lags x, y by exactly one tick.
// Optional build macro VGA_SYNC_FRAME_CNT_EN adds the frame counter;
// without it frame_count is tied to zero.
module vga_sync
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic      clk,
  input  logic      rst,
  vga_sync_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = div_width(CLK_DIV);

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               x_wrap;
  logic               y_wrap;
  logic               visible;
  logic               hs_zone;
  logic               vs_zone;
  logic               frame_pulse;

  // Pixel-clock divider. With CLK_DIV=1 div stays 0 and tick is constant 1.
  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
    end
  end

  vga_counter #(.MODULUS(H_TOTAL), .W(COORD_W)) u_x (
    .clk   (clk),
    .rst   (rst),
    .en    (tick),
    .count (x),
    .wrap  (x_wrap)
  );

  vga_counter #(.MODULUS(V_TOTAL), .W(COORD_W)) u_y (
    .clk   (clk),
    .rst   (rst),
    .en    (x_wrap),
    .count (y),
    .wrap  (y_wrap)
  );

  assign bus.x = x;
  assign bus.y = y;

  assign visible = (x < H_VIS) && (y < V_VIS);
  assign hs_zone = (x >= HS_START) && (x < HS_END);
  assign vs_zone = (y >= VS_START) && (y < VS_END);

  // y_wrap already implies tick and x_wrap: this is the tick that moves
  // the coordinate to 0,0. Reset itself never produces it.
  assign frame_pulse = y_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vga_r       <= '0;
      bus.vga_g       <= '0;
      bus.vga_b       <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.active      <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= frame_pulse;
      if (tick) begin
        bus.vga_r  <= visible ? bus.r : '0;
        bus.vga_g  <= visible ? bus.g : '0;
        bus.vga_b  <= visible ? bus.b : '0;
        bus.hsync  <= ~hs_zone;
        bus.vsync  <= ~vs_zone;
        bus.active <= visible;
      end
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_count;

  // Counts on the same edge that raises frame_start; wraps mod 2^16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
    end else if (frame_pulse) begin
      frame_count <= frame_count + 1'b1;
    end
  end

  assign bus.frame_count = frame_count;
`else
  assign bus.frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_d;
  logic rst_s;

  always #5 clk = ~clk;

  // Default-timing instance (CLK_DIV=2, 640x480) and a shrunken
  // CLK_DIV=1 instance (H 8/2/3/3 = 16, V 6/1/2/1 = 10) for whole frames.
  vga_sync_if d_if ();
  vga_sync_if s_if ();

  vga_sync u_dut (
    .clk (clk),
    .rst (rst_d),
    .bus (d_if)
  );

  vga_sync #(
    .CLK_DIV(1),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .clk (clk),
    .rst (rst_s),
    .bus (s_if)
  );

  // Renderers: constant white on the default instance; the small one
  // paints r=5 only at its last visible pixel (7,5).
  assign d_if.r = 3'd7;
  assign d_if.g = 3'd7;
  assign d_if.b = 3'd7;
  assign s_if.r = (s_if.x == 11'd7 && s_if.y == 11'd5) ? 3'd5 : 3'd0;
  assign s_if.g = 3'd2;
  assign s_if.b = 3'd0;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- vector table (default instance) ----------------
  // n = clk edges since reset release; expected values hand-derived:
  // x = n/2, displayed pixel = n/2 - 1 once n >= 2.
  typedef struct {
    int          n;
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  rgb;
    logic        act;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t vecs[12];
  int   n;
  int   d_fs;
  int   hs_low;
  int   hs_fall;
  logic prev_hs;

  task automatic step_d();
    @(posedge clk);
    @(negedge clk);
    n++;
    if (d_if.frame_start) d_fs++;
    if (!d_if.hsync) hs_low++;
    if (prev_hs && !d_if.hsync && hs_fall < 0) hs_fall = n;
    prev_hs = d_if.hsync;
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < 12; i++) begin
      while (n < vecs[i].n) step_d();
      check($sformatf("%s_v%0d_x", tag, i),      d_if.x,      vecs[i].x);
      check($sformatf("%s_v%0d_y", tag, i),      d_if.y,      vecs[i].y);
      check($sformatf("%s_v%0d_r", tag, i),      d_if.vga_r,  vecs[i].rgb);
      check($sformatf("%s_v%0d_g", tag, i),      d_if.vga_g,  vecs[i].rgb);
      check($sformatf("%s_v%0d_b", tag, i),      d_if.vga_b,  vecs[i].rgb);
      check($sformatf("%s_v%0d_active", tag, i), d_if.active, vecs[i].act);
      check($sformatf("%s_v%0d_hsync", tag, i),  d_if.hsync,  vecs[i].hs);
      check($sformatf("%s_v%0d_vsync", tag, i),  d_if.vsync,  vecs[i].vs);
    end
  endtask

  // ---------------- small-instance reference model ----------------
  int mx, my;

  task automatic run_small(input int edges, output int fs_cnt, output int hs_cnt,
                           output int vs_cnt, output int r5_cnt);
    logic       vis;
    logic [2:0] exp_r, exp_g;
    logic       exp_hs, exp_vs, exp_fs;
    fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; r5_cnt = 0;
    for (int k = 0; k < edges; k++) begin
      vis    = (mx < 8) && (my < 6);
      exp_r  = (mx == 7 && my == 5) ? 3'd5 : 3'd0;
      exp_g  = vis ? 3'd2 : 3'd0;
      exp_hs = !(mx >= 10 && mx < 13);
      exp_vs = !(my >= 7 && my < 9);
      if (mx == 15) begin
        mx = 0;
        my = (my == 9) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      exp_fs = (mx == 0 && my == 0);
      @(posedge clk);
      @(negedge clk);
      check("small_x",      s_if.x,           mx);
      check("small_y",      s_if.y,           my);
      check("small_vga_r",  s_if.vga_r,       exp_r);
      check("small_vga_g",  s_if.vga_g,       exp_g);
      check("small_vga_b",  s_if.vga_b,       0);
      check("small_active", s_if.active,      vis);
      check("small_hsync",  s_if.hsync,       exp_hs);
      check("small_vsync",  s_if.vsync,       exp_vs);
      check("small_fstart", s_if.frame_start, exp_fs);
      if (s_if.frame_start) fs_cnt++;
      if (!s_if.hsync) hs_cnt++;
      if (!s_if.vsync) vs_cnt++;
      if (s_if.vga_r == 3'd5 && s_if.active) r5_cnt++;
    end
  endtask

  // ---------------- main sequence ----------------
  int found;
  int fs_cnt, hs_cnt, vs_cnt, r5_cnt;
  int exp_fc;

  initial begin
    vecs[0]  = '{0,    11'd0,   11'd0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1,    11'd0,   11'd0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{2,    11'd1,   11'd0, 3'd7, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{3,    11'd1,   11'd0, 3'd7, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1280, 11'd640, 11'd0, 3'd7, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1282, 11'd641, 11'd0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1312, 11'd656, 11'd0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1314, 11'd657, 11'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1504, 11'd752, 11'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1506, 11'd753, 11'd0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1600, 11'd0,   11'd1, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1602, 11'd1,   11'd1, 3'd7, 1'b1, 1'b1, 1'b1};

    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_x",      d_if.x,           0);
    check("rst_y",      d_if.y,           0);
    check("rst_vga_r",  d_if.vga_r,       0);
    check("rst_hsync",  d_if.hsync,       1);
    check("rst_vsync",  d_if.vsync,       1);
    check("rst_active", d_if.active,      0);
    check("rst_fstart", d_if.frame_start, 0);
    check("rst_fcount", d_if.frame_count, 0);

    // First line after release
    rst_d = 1'b0;
    n = 0; d_fs = 0; hs_low = 0; hs_fall = -1; prev_hs = 1'b1;
    apply_table("line0");
    check("no_fstart_line0", d_fs, 0);

    // Second line: 96 ticks of hsync low starting 1600 clks after the first
    hs_low = 0; hs_fall = -1;
    while (n < 3300) step_d();
    check("hsync_low_clks", hs_low, 192);
    check("hsync_fall_clk", hs_fall, 2914);

    // Reset in the middle of the hsync pulse
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (d_if.x == 11'd700) found = 1;
      else step_d();
    end
    check("found_x700", found, 1);
    check("x700_hsync_low", d_if.hsync, 0);
    rst_d = 1'b1;
    #1;
    check("midrst_x",      d_if.x,      0);
    check("midrst_y",      d_if.y,      0);
    check("midrst_hsync",  d_if.hsync,  1);
    check("midrst_active", d_if.active, 0);
    repeat (3) @(negedge clk);
    check("midrst_hold_x", d_if.x, 0);
    rst_d = 1'b0;
    n = 0; d_fs = 0; hs_low = 0; hs_fall = -1; prev_hs = 1'b1;
    apply_table("after_rst");
    check("no_fstart_after_rst", d_fs, 0);

    // Small instance: three whole frames at CLK_DIV=1
    check("small_rst_fcount", s_if.frame_count, 0);
    mx = 0; my = 0;
    rst_s = 1'b0;
    run_small(480, fs_cnt, hs_cnt, vs_cnt, r5_cnt);
    check("small_fstart_count", fs_cnt, 3);
    check("small_hsync_low",    hs_cnt, 90);
    check("small_vsync_low",    vs_cnt, 96);
    check("small_r5_count",     r5_cnt, 3);
`ifdef VGA_SYNC_FRAME_CNT_EN
    exp_fc = 3;
`else
    exp_fc = 0;
`endif
    check("small_frame_count", s_if.frame_count, exp_fc);
    check("dflt_frame_count",  d_if.frame_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
